// File: rtl/uart_tx_fifo_drain_pkg.sv
// UART TX drain shared definitions.
// State encodings, data width, default line settings.
package uart_tx_fifo_drain_pkg;

  localparam int DATA_W       = 8;
  localparam int CLK_FREQ_DEF = 100_000_000;
  localparam int BAUD_DEF     = 9600;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } txState_e;

  function automatic int calcDiv(
    input int clkFreq,
    input int baud
  );
    return clkFreq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_drain_baud_cnt.sv
// Free-running bit-period counter, 0..DIV-1.
// Held at zero by iClr; shared with the RX side.
module uart_baud_cnt #(
  parameter int DIV = 10
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic iClr,
  output logic oBitEnd
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < 2) begin : gBadDiv
    $error("uart_baud_cnt: DIV must be >= 2");
  end

  logic [CW-1:0] cnt;

  // Count cycles within a bit, wrap on the bit boundary.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      cnt <= '0;
    end else if (iClr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign oBitEnd = (cnt == LAST);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// 8N1 serializer draining the TX FIFO.
// Pops on !iEmpty, runs frames back-to-back.
module uart_tx_fifo_drain
  import uart_tx_fifo_drain_pkg::*;
#(
  parameter int CLK_FREQ = CLK_FREQ_DEF,
  parameter int BAUD     = BAUD_DEF
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iEmpty,
  input  logic [DATA_W-1:0] iRdData,
  output logic              oPop,
  output logic              oTx,
  output logic              oBusy,
  output logic              oTxDone
);

  localparam int DIV = calcDiv(CLK_FREQ, BAUD);

  if (DIV < 2) begin : gBadDiv
    $error("uart_tx_fifo_drain: CLK_FREQ/BAUD must be >= 2");
  end

  txState_e          state;
  txState_e          stateNxt;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] shiftNxt;
  logic [2:0]        idx;
  logic [2:0]        idxNxt;
  logic              txNxt;
  logic              popNxt;
  logic              busyNxt;
  logic              doneNxt;
  logic              bitEnd;

  uart_baud_cnt #(
    .DIV (DIV)
  ) uBaud (
    .iClk    (iClk),
    .iRst_n  (iRst_n),
    .iClr    (state == IDLE),
    .oBitEnd (bitEnd)
  );

  // Next state and next registered outputs.
  always_comb begin
    stateNxt = state;
    shiftNxt = shift;
    idxNxt   = idx;
    txNxt    = oTx;
    popNxt   = 1'b0;
    doneNxt  = 1'b0;
    unique case (state)
      IDLE: begin
        txNxt = 1'b1;
        if (!iEmpty) begin
          shiftNxt = iRdData;
          popNxt   = 1'b1;
          txNxt    = 1'b0;
          stateNxt = START;
        end
      end
      START: begin
        if (bitEnd) begin
          stateNxt = DATA;
          idxNxt   = '0;
          txNxt    = shift[0];
        end
      end
      DATA: begin
        if (bitEnd) begin
          shiftNxt = {1'b0, shift[DATA_W-1:1]};
          idxNxt   = idx + 3'd1;
          if (idx == 3'd7) begin
            stateNxt = STOP;
            txNxt    = 1'b1;
          end else begin
            txNxt = shift[1];
          end
        end
      end
      STOP: begin
        if (bitEnd) begin
          doneNxt = 1'b1;
          if (!iEmpty) begin
            shiftNxt = iRdData;
            popNxt   = 1'b1;
            txNxt    = 1'b0;
            stateNxt = START;
          end else begin
            txNxt    = 1'b1;
            stateNxt = IDLE;
          end
        end
      end
      default: begin
        txNxt    = 1'b1;
        stateNxt = IDLE;
      end
    endcase
    busyNxt = (stateNxt != IDLE);
  end

  // Register state, datapath and all outputs.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state   <= IDLE;
      shift   <= '0;
      idx     <= '0;
      oTx     <= 1'b1;
      oPop    <= 1'b0;
      oBusy   <= 1'b0;
      oTxDone <= 1'b0;
    end else begin
      state   <= stateNxt;
      shift   <= shiftNxt;
      idx     <= idxNxt;
      oTx     <= txNxt;
      oPop    <= popNxt;
      oBusy   <= busyNxt;
      oTxDone <= doneNxt;
    end
  end

endmodule
